// File: rtl/ns_msg_fifo.sv
// rtl/ns_msg_fifo.sv - 4-phase req/ack message FIFO between producer and consumer
// Optional redundancy check on ingress enabled by NS_FIFO_REDUN_CHK_EN.

`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 4
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

`ifdef NS_FIFO_REDUN_CHK_EN
module calc_redun #(
    parameter int ASZ = `NS_ADDRESS_SIZE,
    parameter int DSZ = `NS_DATA_SIZE,
    parameter int RSZ = `NS_REDUN_SIZE
) (
    input  logic [ASZ-1:0] src,
    input  logic [ASZ-1:0] dst,
    input  logic [DSZ-1:0] dat,
    output logic [RSZ-1:0] red
);
    localparam int W = 2*ASZ + DSZ;
    localparam int N = (W + RSZ - 1) / RSZ;

    logic [N*RSZ-1:0] flat;

    // XOR-fold the concatenated header and payload into RSZ-bit chunks
    always_comb begin
        flat = '0;
        flat[W-1:0] = {src, dst, dat};
        red = '0;
        for (int i = 0; i < N; i++)
            red = red ^ flat[i*RSZ +: RSZ];
    end
endmodule
`endif

module ns_msg_fifo #(
    parameter int FSZ = 2,
    parameter int ASZ = `NS_ADDRESS_SIZE,
    parameter int DSZ = `NS_DATA_SIZE,
    parameter int RSZ = `NS_REDUN_SIZE
) (
    input  logic           i_clk,
    input  logic           reset,
    input  logic [ASZ-1:0] i0_src,
    input  logic [ASZ-1:0] i0_dst,
    input  logic [DSZ-1:0] i0_dat,
    input  logic [RSZ-1:0] i0_red,
    input  logic           i0_req,
    output logic           i0_ack,
    output logic [ASZ-1:0] o0_src,
    output logic [ASZ-1:0] o0_dst,
    output logic [DSZ-1:0] o0_dat,
    output logic [RSZ-1:0] o0_red,
    output logic           o0_req,
    input  logic           o0_ack,
    output logic [FSZ:0]   o_cnt,
    output logic           o_full,
    output logic           o_empty,
    output logic           o_err
);
    localparam int DEPTH = 1 << FSZ;
    localparam int MW    = 2*ASZ + DSZ + RSZ;

    typedef enum logic {IN_IDLE, IN_ACK}   in_state_t;
    typedef enum logic {OUT_IDLE, OUT_REQ} out_state_t;

    in_state_t     in_st;
    out_state_t    out_st;
    logic [MW-1:0] mem [DEPTH];
    logic [FSZ-1:0] wr_ptr;
    logic [FSZ-1:0] rd_ptr;
    logic [FSZ:0]  count;
    logic          push;
    logic          store;
    logic          pop;
    logic          load;

    assign o_cnt   = count;
    assign o_full  = (count == (FSZ+1)'(DEPTH));
    assign o_empty = (count == '0);

    // Full and empty come from pre-edge count, so a pop never admits a push on the same edge
    assign push = (in_st == IN_IDLE) && i0_req && !o_full;
    assign pop  = (out_st == OUT_REQ) && o0_ack;
    assign load = (out_st == OUT_IDLE) && !o_empty && !o0_ack;

`ifdef NS_FIFO_REDUN_CHK_EN
    logic [RSZ-1:0] red_calc;
    logic           err_q;

    calc_redun #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) u_calc_redun (
        .src (i0_src),
        .dst (i0_dst),
        .dat (i0_dat),
        .red (red_calc)
    );

    // Corrupt messages are still acknowledged so the producer never stalls
    assign store = push && (i0_red == red_calc);
    assign o_err = err_q;

    always_ff @(posedge i_clk) begin
        if (!reset)
            err_q <= 1'b0;
        else if (push && (i0_red != red_calc))
            err_q <= 1'b1;
    end
`else
    assign store = push;
    assign o_err = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (store)
            mem[wr_ptr] <= {i0_src, i0_dst, i0_dat, i0_red};
    end

    always_ff @(posedge i_clk) begin
        if (!reset) begin
            in_st  <= IN_IDLE;
            out_st <= OUT_IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            i0_ack <= 1'b0;
            o0_req <= 1'b0;
            o0_src <= '0;
            o0_dst <= '0;
            o0_dat <= '0;
            o0_red <= '0;
        end else begin
            case (in_st)
                IN_IDLE: if (push) begin
                    in_st  <= IN_ACK;
                    i0_ack <= 1'b1;
                end
                IN_ACK: if (!i0_req) begin
                    in_st  <= IN_IDLE;
                    i0_ack <= 1'b0;
                end
                default: in_st <= IN_IDLE;
            endcase

            if (store)
                wr_ptr <= wr_ptr + 1'b1;

            case (out_st)
                OUT_IDLE: if (load) begin
                    out_st <= OUT_REQ;
                    o0_req <= 1'b1;
                    {o0_src, o0_dst, o0_dat, o0_red} <= mem[rd_ptr];
                end
                OUT_REQ: if (pop) begin
                    out_st <= OUT_IDLE;
                    o0_req <= 1'b0;
                    rd_ptr <= rd_ptr + 1'b1;
                end
                default: out_st <= OUT_IDLE;
            endcase

            case ({store, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_ns_msg_fifo.sv
// tb/tb_ns_msg_fifo.sv - scoreboard bench for ns_msg_fifo (FSZ=2, 4/4/8/4 field widths)

module tb_ns_msg_fifo;
    typedef logic [19:0] msg_t;

    logic       i_clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] i0_src = '0;
    logic [3:0] i0_dst = '0;
    logic [7:0] i0_dat = '0;
    logic [3:0] i0_red = '0;
    logic       i0_req = 1'b0;
    logic       i0_ack;
    logic [3:0] o0_src;
    logic [3:0] o0_dst;
    logic [7:0] o0_dat;
    logic [3:0] o0_red;
    logic       o0_req;
    logic       o0_ack;
    logic [2:0] o_cnt;
    logic       o_full;
    logic       o_empty;
    logic       o_err;

    logic       mon_ack = 1'b0;
    logic       man_ack = 1'b0;
    bit         cons_en = 1'b0;
    int         cons_max = 0;
    int         checks = 0;
    int         errors = 0;
    int         rx_cnt = 0;
    int         max_cnt = 0;
    msg_t       exp_q[$];

    assign o0_ack = mon_ack | man_ack;

    ns_msg_fifo #(.FSZ(2), .ASZ(4), .DSZ(8), .RSZ(4)) dut (
        .i_clk   (i_clk),
        .reset   (reset),
        .i0_src  (i0_src),
        .i0_dst  (i0_dst),
        .i0_dat  (i0_dat),
        .i0_red  (i0_red),
        .i0_req  (i0_req),
        .i0_ack  (i0_ack),
        .o0_src  (o0_src),
        .o0_dst  (o0_dst),
        .o0_dat  (o0_dat),
        .o0_red  (o0_red),
        .o0_req  (o0_req),
        .o0_ack  (o0_ack),
        .o_cnt   (o_cnt),
        .o_full  (o_full),
        .o_empty (o_empty),
        .o_err   (o_err)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [3:0] red_of(input logic [3:0] s, input logic [3:0] d, input logic [7:0] dt);
        return s ^ d ^ dt[7:4] ^ dt[3:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push_msg(input logic [3:0] s, input logic [3:0] d, input logic [7:0] dt,
                            input logic [3:0] r, input bit store);
        bit ok;
        @(negedge i_clk);
        i0_src = s; i0_dst = d; i0_dat = dt; i0_red = r; i0_req = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge i_clk);
            if (i0_ack) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL push_ack dat=%0h: ack 0 want 1", dt);
        end else if (store) begin
            exp_q.push_back({s, d, dt, r});
        end
        i0_req = 1'b0;
        for (int i = 0; i < 20 && i0_ack; i++) @(negedge i_clk);
    endtask

    task automatic drain();
        bit done;
        cons_en = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge i_clk);
            if (exp_q.size() == 0 && o_empty && !o0_req && !mon_ack) begin done = 1'b1; break; end
        end
        check("drain_done", {31'd0, done}, 32'd1);
        cons_en = 1'b0;
    endtask

    // Scoreboard monitor: compares every presented message, then completes the handshake
    initial begin
        int   dly;
        bit   gone;
        msg_t exp_m;
        forever begin
            @(negedge i_clk);
            if (cons_en && reset && o0_req && !mon_ack) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got %0h want none", {o0_src, o0_dst, o0_dat, o0_red});
                end else begin
                    exp_m = exp_q.pop_front();
                    if ({o0_src, o0_dst, o0_dat, o0_red} !== exp_m) begin
                        errors++;
                        $display("FAIL sb_msg: got %0h want %0h", {o0_src, o0_dst, o0_dat, o0_red}, exp_m);
                    end
                end
                rx_cnt++;
                dly = $urandom_range(0, cons_max);
                repeat (dly) @(negedge i_clk);
                mon_ack = 1'b1;
                gone = 1'b0;
                for (int i = 0; i < 20; i++) begin
                    @(negedge i_clk);
                    if (!o0_req) begin gone = 1'b1; break; end
                end
                check("sb_req_drop", {31'd0, gone}, 32'd1);
                mon_ack = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge i_clk);
            if (int'(o_cnt) > max_cnt) max_cnt = int'(o_cnt);
        end
    end

    initial begin
        msg_t m;
        int   rx0;

        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        reset = 1'b1;
        check("rst_i0_ack", {31'd0, i0_ack}, 32'd0);
        check("rst_o0_req", {31'd0, o0_req}, 32'd0);
        check("rst_o0_msg", {12'd0, o0_src, o0_dst, o0_dat, o0_red}, 32'd0);
        check("rst_cnt", {29'd0, o_cnt}, 32'd0);
        check("rst_empty", {31'd0, o_empty}, 32'd1);
        check("rst_full", {31'd0, o_full}, 32'd0);
        check("rst_err", {31'd0, o_err}, 32'd0);

        // Single message latency: src=0 dst=1 dat=5 red=4
        @(negedge i_clk);
        i0_src = 4'd0; i0_dst = 4'd1; i0_dat = 8'd5; i0_red = 4'd4; i0_req = 1'b1;
        @(posedge i_clk); #1;
        check("lat_ack_k", {31'd0, i0_ack}, 32'd1);
        check("lat_cnt_k", {29'd0, o_cnt}, 32'd1);
        check("lat_req_k", {31'd0, o0_req}, 32'd0);
        @(posedge i_clk); #1;
        check("lat_req_k1", {31'd0, o0_req}, 32'd1);
        check("lat_msg_k1", {12'd0, o0_src, o0_dst, o0_dat, o0_red}, {12'd0, 4'd0, 4'd1, 8'd5, 4'd4});
        @(negedge i_clk);
        i0_req = 1'b0; man_ack = 1'b1;
        @(posedge i_clk); #1;
        check("lat_req_drop", {31'd0, o0_req}, 32'd0);
        check("lat_empty", {31'd0, o_empty}, 32'd1);
        @(negedge i_clk);
        man_ack = 1'b0;

        // Fill, blocked push, deferred admission after one pop
        for (int i = 0; i < 4; i++)
            push_msg(4'd2, 4'd3, 8'(i), red_of(4'd2, 4'd3, 8'(i)), 1'b1);
        check("fill_cnt", {29'd0, o_cnt}, 32'd4);
        check("fill_full", {31'd0, o_full}, 32'd1);
        @(negedge i_clk);
        i0_src = 4'd2; i0_dst = 4'd3; i0_dat = 8'd4; i0_red = red_of(4'd2, 4'd3, 8'd4); i0_req = 1'b1;
        repeat (3) @(negedge i_clk);
        check("full_blocked", {31'd0, i0_ack}, 32'd0);
        m = exp_q.pop_front();
        check("fill_head", {12'd0, o0_src, o0_dst, o0_dat, o0_red}, {12'd0, m});
        man_ack = 1'b1;
        @(posedge i_clk); #1;
        check("pop_edge_no_ack", {31'd0, i0_ack}, 32'd0);
        check("pop_edge_cnt", {29'd0, o_cnt}, 32'd3);
        @(negedge i_clk);
        man_ack = 1'b0;
        @(posedge i_clk); #1;
        check("deferred_ack", {31'd0, i0_ack}, 32'd1);
        check("deferred_cnt", {29'd0, o_cnt}, 32'd4);
        exp_q.push_back({4'd2, 4'd3, 8'd4, red_of(4'd2, 4'd3, 8'd4)});
        @(negedge i_clk);
        i0_req = 1'b0;
        drain();

        // Simultaneous push and pop at count 2
        push_msg(4'd5, 4'd6, 8'h20, red_of(4'd5, 4'd6, 8'h20), 1'b1);
        push_msg(4'd5, 4'd6, 8'h21, red_of(4'd5, 4'd6, 8'h21), 1'b1);
        @(negedge i_clk);
        check("pp_cnt_before", {29'd0, o_cnt}, 32'd2);
        m = exp_q.pop_front();
        check("pp_head", {12'd0, o0_src, o0_dst, o0_dat, o0_red}, {12'd0, m});
        man_ack = 1'b1;
        i0_src = 4'd5; i0_dst = 4'd6; i0_dat = 8'h22; i0_red = red_of(4'd5, 4'd6, 8'h22); i0_req = 1'b1;
        @(posedge i_clk); #1;
        check("pp_cnt_after", {29'd0, o_cnt}, 32'd2);
        check("pp_ack", {31'd0, i0_ack}, 32'd1);
        exp_q.push_back({4'd5, 4'd6, 8'h22, red_of(4'd5, 4'd6, 8'h22)});
        @(negedge i_clk);
        man_ack = 1'b0; i0_req = 1'b0;
        drain();

        // Wrap: 20 messages against a randomly delayed consumer
        rx0 = rx_cnt;
        max_cnt = 0;
        cons_max = 3;
        cons_en = 1'b1;
        for (int i = 0; i < 20; i++)
            push_msg(4'(i), 4'(i + 3), 8'(i % 16), red_of(4'(i), 4'(i + 3), 8'(i % 16)), 1'b1);
        drain();
        check("wrap_rx", rx_cnt - rx0, 32'd20);
        check("wrap_max_cnt", max_cnt, max_cnt <= 4 ? max_cnt : 4);
        cons_max = 0;

        // Reset mid-transfer
        for (int i = 0; i < 3; i++)
            push_msg(4'd7, 4'd8, 8'(8'h30 + i), red_of(4'd7, 4'd8, 8'(8'h30 + i)), 1'b1);
        @(negedge i_clk);
        check("mid_cnt", {29'd0, o_cnt}, 32'd3);
        check("mid_req", {31'd0, o0_req}, 32'd1);
        reset = 1'b0;
        @(posedge i_clk); #1;
        check("mid_rst_req", {31'd0, o0_req}, 32'd0);
        check("mid_rst_ack", {31'd0, i0_ack}, 32'd0);
        check("mid_rst_cnt", {29'd0, o_cnt}, 32'd0);
        check("mid_rst_empty", {31'd0, o_empty}, 32'd1);
        @(negedge i_clk);
        reset = 1'b1;
        exp_q.delete();
        push_msg(4'd1, 4'd2, 8'd9, red_of(4'd1, 4'd2, 8'd9), 1'b1);
        drain();

`ifdef NS_FIFO_REDUN_CHK_EN
        push_msg(4'd3, 4'd4, 8'd7, red_of(4'd3, 4'd4, 8'd7) ^ 4'h1, 1'b0);
        check("redun_cnt", {29'd0, o_cnt}, 32'd0);
        check("redun_err", {31'd0, o_err}, 32'd1);
        push_msg(4'd3, 4'd4, 8'd8, red_of(4'd3, 4'd4, 8'd8), 1'b1);
        drain();
        check("redun_err_sticky", {31'd0, o_err}, 32'd1);
`else
        check("err_tied_low", {31'd0, o_err}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end
endmodule
